// File: rtl/ctrl_xfer_pipe.sv
// EX/MEM control-transfer record pipeline feeding the hazard unit, with a
// RUN/DRAIN squash state machine and saturating flush / taken-transfer counters.
module ctrl_xfer_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             id_valid,
  input  logic             id_jal,
  input  logic             id_jreg,
  input  logic             id_jump,
  input  logic             id_bne,
  input  logic             id_beq,
  input  logic             ex_zero,
  input  logic             flush,
  output logic             mem_jal,
  output logic             mem_jreg,
  output logic             mem_jump,
  output logic             mem_bne,
  output logic             mem_beq,
  output logic             mem_zero,
  output logic             mem_valid,
  output logic             mem_taken,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam int FL_BEQ  = 0;
  localparam int FL_BNE  = 1;
  localparam int FL_JUMP = 2;
  localparam int FL_JREG = 3;
  localparam int FL_JAL  = 4;

  state_e           state_q;
  logic             ex_valid_q;
  logic [4:0]       ex_flags_q;
  logic             mem_valid_q;
  logic [4:0]       mem_flags_q;
  logic             mem_zero_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] xfer_cnt_q;

  logic             ex_valid_d;
  logic [4:0]       ex_flags_d;
  logic             mem_zero_d;
  logic             taken;
  logic             flush_cnt_full;
  logic             xfer_cnt_full;

  // A stage loaded invalid carries no flags, so downstream logic can trust flags alone.
  always_comb begin
    ex_valid_d = 1'b0;
    ex_flags_d = 5'b0;
    if (state_q == ST_RUN && id_valid) begin
      ex_valid_d = 1'b1;
      ex_flags_d = {id_jal, id_jreg, id_jump, id_bne, id_beq};
    end
  end

  assign mem_zero_d = ex_zero & (ex_flags_q[FL_BEQ] | ex_flags_q[FL_BNE]);

  assign taken = mem_valid_q & (mem_flags_q[FL_JAL] | mem_flags_q[FL_JREG] |
                                mem_flags_q[FL_JUMP] |
                                (mem_flags_q[FL_BEQ] & mem_zero_q) |
                                (mem_flags_q[FL_BNE] & ~mem_zero_q));

  assign flush_cnt_full = &flush_cnt_q;
  assign xfer_cnt_full  = &xfer_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUN;
      ex_valid_q  <= 1'b0;
      ex_flags_q  <= 5'b0;
      mem_valid_q <= 1'b0;
      mem_flags_q <= 5'b0;
      mem_zero_q  <= 1'b0;
      flush_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      if (flush && !flush_cnt_full) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
      if (taken && !xfer_cnt_full) begin
        xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
      end

      if (flush) begin
        state_q     <= ST_DRAIN;
        ex_valid_q  <= 1'b0;
        ex_flags_q  <= 5'b0;
        mem_valid_q <= 1'b0;
        mem_flags_q <= 5'b0;
        mem_zero_q  <= 1'b0;
      end else if (en) begin
        // In DRAIN the decode slot is wrong-path, so ex_valid_d squashes it.
        state_q     <= ST_RUN;
        ex_valid_q  <= ex_valid_d;
        ex_flags_q  <= ex_flags_d;
        mem_valid_q <= ex_valid_q;
        mem_flags_q <= ex_flags_q;
        mem_zero_q  <= mem_zero_d;
      end
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_jal   = mem_flags_q[FL_JAL];
  assign mem_jreg  = mem_flags_q[FL_JREG];
  assign mem_jump  = mem_flags_q[FL_JUMP];
  assign mem_bne   = mem_flags_q[FL_BNE];
  assign mem_beq   = mem_flags_q[FL_BEQ];
  assign mem_zero  = mem_zero_q;
  assign mem_taken = taken;
  assign flush_cnt = flush_cnt_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: doc/ctrl_xfer_pipe.md
CTRL_XFER_PIPE -- requirements
Module: ctrl_xfer_pipe

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of both performance counters.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1, the reset: synchronous and active-high.
REQ-004 The block SHALL have port en, input, 1, pipeline advance enable (ID->EX->MEM shift).
REQ-005 The block SHALL have port id_valid, input, 1, decode stage holds a real instruction.
REQ-006 The block SHALL have ports id_jal, id_jreg, id_jump, id_bne, id_beq, input, 1 each, decoded control-transfer flags.
REQ-007 The block SHALL have port ex_zero, input, 1, ALU zero result for the instruction in EX.
REQ-008 The block SHALL have port flush, input, 1, flush request from the hazard unit.
REQ-009 The block SHALL have ports mem_jal, mem_jreg, mem_jump, mem_bne, mem_beq, mem_zero, output, 1 each, the MEM-stage hazard record driven to the hazard unit.
REQ-010 The block SHALL have port mem_valid, output, 1, MEM stage holds a real instruction.
REQ-011 The block SHALL have port mem_taken, output, 1, combinational: mem_valid & (jal | jreg | jump | (beq & zero) | (bne & ~zero)).
REQ-012 The block SHALL have ports flush_cnt and xfer_cnt, output, CNT_W each, saturating event counters.

Function
REQ-013 Two register stages SHALL exist: EX stage (valid + five flags) and MEM stage (valid + five flags + zero).
REQ-014 With en=1, flush=0, state RUN: EX SHALL load id_valid and id flags; MEM SHALL load EX contents with mem_zero <= ex_zero.
REQ-015 mem_zero SHALL capture ex_zero only when the EX instruction is beq or bne; otherwise 0.
REQ-016 When a stage is loaded with valid=0, all its flags SHALL be 0; outputs never show flags with mem_valid=0.
REQ-017 With en=0 and flush=0, both stages SHALL hold their contents.
REQ-018 flush=1 SHALL take priority over en: at the edge, EX and MEM valid and all flags SHALL clear, regardless of en.
REQ-019 State machine, two states: RUN (reset state) and DRAIN.
REQ-020 RUN -> DRAIN at an edge with flush=1; DRAIN -> RUN at the first subsequent edge with en=1 and flush=0.
REQ-021 In DRAIN, an en=1 edge SHALL load EX with valid=0 (wrong-path decode squashed) and shift EX into MEM normally.
REQ-022 flush=1 while in DRAIN SHALL clear both stages again and remain in DRAIN.
REQ-023 flush_cnt SHALL increment by 1 at every edge with flush=1, saturating at all-ones.
REQ-024 xfer_cnt SHALL increment by 1 at every edge where mem_taken=1, saturating at all-ones.
REQ-025 Simultaneous flush and mem_taken at one edge SHALL increment both counters.
REQ-026 Latency: an instruction valid in ID at edge N (en=1 at N and N+1, no flush) SHALL appear at MEM outputs after edge N+1.

Reset
REQ-027 RST=1 at an edge SHALL override all other inputs: state RUN, both stages invalid with flags 0, mem_zero 0, flush_cnt 0, xfer_cnt 0.
REQ-028 After that edge all outputs SHALL be 0, including mem_taken; reset asserted mid-DRAIN or mid-flush SHALL behave identically.

Verification
REQ-029 Reset: RST=1 one edge with arbitrary inputs -> all outputs 0, state RUN.
REQ-030 Beq taken: id_valid=1, id_beq=1, en=1 two edges, ex_zero=1 at second edge -> mem_valid=1, mem_beq=1, mem_zero=1, mem_taken=1; next edge xfer_cnt=1.
REQ-031 Bne not taken: id_bne=1, ex_zero=1 -> mem_bne=1, mem_zero=1, mem_taken=0, xfer_cnt unchanged.
REQ-032 Flush priority: MEM holds jal, flush=1, en=0 -> next edge mem_valid=0, flags 0, flush_cnt=1, state DRAIN; following en=1 edge with id_valid=1 -> EX invalid, state RUN.
REQ-033 Stall: en=0 for 3 edges with MEM holding jump -> mem_jump=1 held; mem_taken=1 each edge, xfer_cnt +3.
REQ-034 Saturation: CNT_W=4, 20 flush edges -> flush_cnt=15 and holds.
